// File: rtl/singlecycle_pkg.sv
// Shared LSU types: controller states and RV32I load/store funct3 encodings.
package singlecycle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask/replication, load extraction,
// and misalign/illegal-encoding detection.
module lsu_align
    import singlecycle_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        wren,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  bmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        bad
);

    logic [7:0]  r_byte;
    logic [15:0] r_half;

    assign r_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign r_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        bmask     = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        bad       = 1'b0;
        case (funct3)
            LSU_B, LSU_BU: begin
                bmask     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'd0, r_byte} : {{24{r_byte[7]}}, r_byte};
            end
            LSU_H, LSU_HU: begin
                bad       = addr_lo[0];
                bmask     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'd0, r_half} : {{16{r_half[15]}}, r_half};
            end
            LSU_W: begin
                bad   = |addr_lo;
                bmask = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
        // unsigned variants exist only for loads
        if (wren && funct3[2])
            bad = 1'b1;
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Single-outstanding load/store initiator toward data memory (VALID/READY).
// Optional BUSY watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_if
    import singlecycle_pkg::*;
#(
    parameter int ADDR_W = 18
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wren,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    input  logic [31:0] i_RDATA,
    output logic        o_VALID,
    input  logic        i_READY
);

    localparam logic [31:0] ADDR_MASK = (32'd1 << ADDR_W) - 32'd1;

    lsu_state_e  state_q, state_d;
    logic [2:0]  rq_funct3;
    logic [1:0]  rq_addr_lo;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic        al_wren;
    logic [3:0]  al_bmask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_bad;
    logic        req_bad;
    logic        accept;
    logic        hs;
    logic        to_hit;

    // one aligner: incoming request while IDLE, latched request while BUSY
    assign al_funct3  = (state_q == IDLE) ? i_req_funct3     : rq_funct3;
    assign al_addr_lo = (state_q == IDLE) ? i_req_addr[1:0]  : rq_addr_lo;
    assign al_wren    = (state_q == IDLE) ? i_req_wren       : o_WREN;

    lsu_align u_align (
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wren      (al_wren),
        .wdata     (i_req_wdata),
        .rdata     (i_RDATA),
        .bmask     (al_bmask),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .bad       (al_bad)
    );

    assign req_bad     = al_bad | (|(i_req_addr & ~ADDR_MASK));
    assign accept      = (state_q == IDLE) & i_req_valid;
    assign hs          = (state_q == BUSY) & i_READY;
    assign o_VALID     = (state_q == BUSY);
    assign o_req_ready = (state_q == IDLE);

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            to_cnt <= '0;
        else if (state_q != BUSY)
            to_cnt <= '0;
        else if (!i_READY)
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (state_q == BUSY) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req_valid) state_d = req_bad ? ERR : BUSY;
            BUSY:    if (i_READY) state_d = IDLE;
                     else if (to_hit) state_d = ERR;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rq_funct3   <= '0;
            rq_addr_lo  <= '0;
            o_ADDR      <= '0;
            o_WDATA     <= '0;
            o_BMASK     <= '0;
            o_WREN      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            if (accept) begin
                rq_funct3  <= i_req_funct3;
                rq_addr_lo <= i_req_addr[1:0];
                o_ADDR     <= 18'(i_req_addr & ADDR_MASK);
                o_WDATA    <= al_wdata;
                o_BMASK    <= al_bmask;
                o_WREN     <= i_req_wren;
                if (req_bad) begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b1;
                end
            end
            if (hs) begin
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b0;
                if (!o_WREN)
                    o_rsp_rdata <= al_rdata;
            end else if (to_hit) begin
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed + randomized bench for lsu_mem_if against an arithmetic reference model.
module tb_lsu_mem_if;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wren;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [17:0] o_ADDR;
    logic [31:0] o_WDATA;
    logic [3:0]  o_BMASK;
    logic        o_WREN;
    logic [31:0] i_RDATA;
    logic        o_VALID;
    logic        i_READY;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 i_clk = ~i_clk;

    lsu_mem_if #(
`ifdef LSU_TIMEOUT_EN
        .ADDR_W(18), .TIMEOUT_CYC(8)
`else
        .ADDR_W(18)
`endif
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wren(i_req_wren), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_ADDR(o_ADDR), .o_WDATA(o_WDATA), .o_BMASK(o_BMASK), .o_WREN(o_WREN),
        .i_RDATA(i_RDATA), .o_VALID(o_VALID), .i_READY(i_READY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit ref_bad(input bit wr, input bit [2:0] f3, input bit [31:0] a);
        int unsigned fi = f3;
        if (fi == 3 || fi >= 6) return 1'b1;
        if (wr && fi >= 4) return 1'b1;
        if ((fi == 1 || fi == 5) && (a % 2) != 0) return 1'b1;
        if (fi == 2 && (a % 4) != 0) return 1'b1;
        if (a >= 32'h0004_0000) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int unsigned ref_size(input bit [2:0] f3);
        int unsigned lo = f3 % 4;
        return (lo == 0) ? 1 : (lo == 1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_mask(input bit [2:0] f3, input bit [31:0] a);
        int unsigned sz = ref_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input bit [2:0] f3, input bit [31:0] wd);
        longint unsigned v;
        case (ref_size(f3))
            1:       v = (longint'(wd) & 64'hFF) * 64'h0101_0101;
            2:       v = (longint'(wd) & 64'hFFFF) * 64'h0001_0001;
            default: v = longint'(wd);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
        int unsigned sz = ref_size(f3);
        longint unsigned lim, v;
        if (sz == 4) return rd;
        lim = 64'd1 << (8 * sz);
        v = (longint'(rd) >> (8 * (a % 4))) % lim;
        if (f3 < 4 && v >= lim / 2) v = v + (64'hFFFF_FFFF - lim + 1);
        return v[31:0];
    endfunction

    // one complete transaction; memory acks on the (dly+1)-th VALID cycle
    task automatic run_req(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                           input bit [31:0] wd, input bit [31:0] rd, input int dly);
        bit bad = ref_bad(wr, f3, a);
        @(negedge i_clk);
        chk("idle_ready", {31'd0, o_req_ready}, 32'd1);
        chk("idle_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        i_req_valid = 1'b1; i_req_wren = wr; i_req_funct3 = f3;
        i_req_addr = a; i_req_wdata = wd;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_req_wdata = $urandom;
        if (bad) begin
            chk("err_no_valid", {31'd0, o_VALID}, 32'd0);
            chk("err_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("err_rsp_err", {31'd0, o_rsp_err}, 32'd1);
            chk("err_rdata_held", o_rsp_rdata, exp_rdata);
            chk("err_ready_low", {31'd0, o_req_ready}, 32'd0);
        end else begin
            for (int c = 0; c <= dly; c++) begin
                chk("busy_valid", {31'd0, o_VALID}, 32'd1);
                chk("busy_ready_low", {31'd0, o_req_ready}, 32'd0);
                chk("busy_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
                chk("busy_addr", {14'd0, o_ADDR}, a);
                chk("busy_bmask", {28'd0, o_BMASK}, {28'd0, ref_mask(f3, a)});
                chk("busy_wren", {31'd0, o_WREN}, {31'd0, wr});
                if (wr) chk("busy_wdata", o_WDATA, ref_wdata(f3, wd));
                i_READY = (c == dly);
                i_RDATA = (c == dly) ? rd : $urandom;
                @(negedge i_clk);
            end
            i_READY = 1'b0;
            i_RDATA = $urandom;
            if (!wr) exp_rdata = ref_load(f3, a, rd);
            chk("done_valid_low", {31'd0, o_VALID}, 32'd0);
            chk("done_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("done_rsp_err", {31'd0, o_rsp_err}, 32'd0);
            chk("done_rdata", o_rsp_rdata, exp_rdata);
        end
    endtask

    initial begin
        bit [2:0] f3_tab [8];
        int cnt;
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b010, 3'b011};
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_wren = 1'b0; i_req_funct3 = 3'd0;
        i_req_addr = 32'd0; i_req_wdata = 32'd0; i_RDATA = 32'd0; i_READY = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_valid", {31'd0, o_VALID}, 32'd0);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        chk("rst_rdata", o_rsp_rdata, 32'd0);
        chk("rst_addr", {14'd0, o_ADDR}, 32'd0);
        chk("rst_wdata", o_WDATA, 32'd0);
        chk("rst_bmask", {28'd0, o_BMASK}, 32'd0);
        chk("rst_wren", {31'd0, o_WREN}, 32'd0);
        i_rst_n = 1'b1;

        run_req(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'd0, 0);
        chk("sb_mask_value", {28'd0, o_BMASK}, 32'h8);
        chk("sb_wdata_value", o_WDATA, 32'hA5A5_A5A5);
        run_req(1'b0, 3'b000, 32'h0000_0002, 32'd0, 32'h1280_3344, 0);
        chk("lb_value", o_rsp_rdata, 32'hFFFF_FF80);
        run_req(1'b0, 3'b100, 32'h0000_0002, 32'd0, 32'h1280_3344, 0);
        chk("lbu_value", o_rsp_rdata, 32'h0000_0080);
        run_req(1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'h1280_3344, 0);
        chk("lhu_value", o_rsp_rdata, 32'h0000_1280);
        run_req(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0);
        run_req(1'b0, 3'b010, 32'h0004_0000, 32'd0, 32'd0, 0);
        run_req(1'b0, 3'b011, 32'h0000_0000, 32'd0, 32'd0, 0);
        run_req(1'b1, 3'b100, 32'h0000_0000, 32'd0, 32'd0, 0);
        run_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 5);
        run_req(1'b1, 3'b001, 32'h0003_FFFE, 32'h0000_BEEF, 32'd0, 1);
        chk("sh_hi_mask", {28'd0, o_BMASK}, 32'hC);

        // reset during BUSY: VALID falls asynchronously, no response appears
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_wren = 1'b1; i_req_funct3 = 3'b010;
        i_req_addr = 32'h0000_0020; i_req_wdata = 32'h1234_5678;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("mid_valid_pre", {31'd0, o_VALID}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1 chk("mid_valid_async", {31'd0, o_VALID}, 32'd0);
        exp_rdata = 32'd0;
        @(negedge i_clk);
        chk("mid_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("mid_no_rsp_after", {31'd0, o_rsp_valid}, 32'd0);
        run_req(1'b0, 3'b001, 32'h0000_0022, 32'd0, 32'h8001_7FFF, 2);

        for (int i = 0; i < 40; i++) begin
            bit [2:0]  f3 = f3_tab[$urandom_range(0, 7)];
            bit        wr = 1'($urandom_range(0, 1));
            bit [31:0] a  = $urandom_range(0, 32'h3FFFF);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(ref_size(f3) - 1);
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(18, 31));
            run_req(wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
        end

`ifdef LSU_TIMEOUT_EN
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_wren = 1'b0; i_req_funct3 = 3'b010;
        i_req_addr = 32'h0000_0100;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        cnt = 0;
        while (o_VALID === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge i_clk);
        end
        chk("to_valid_cycles", cnt, 32'd8);
        chk("to_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        chk("to_rsp_err", {31'd0, o_rsp_err}, 32'd1);
        chk("to_rdata_held", o_rsp_rdata, exp_rdata);
        run_req(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'hCAFE_F00D, 7);
`else
        cnt = 0;
`endif
        @(negedge i_clk);
        chk("final_ready", {31'd0, o_req_ready}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store initiator between the core's memory stage and data_mem: accepts one RV32I load/store, drives the VALID/READY request side of the data memory, returns aligned/sign-extended load data or an error.
- Store side: computes byte mask and byte-lane replication. Load side: lane extraction and extension.
- One request outstanding; works with both flop-based (READY always 1) and SRAM-based (multi-cycle READY) data memory.

Parameters:
ADDR_W, 18, implemented byte-address width; any set bit in i_addr[31:ADDR_W] is an access fault
TIMEOUT_CYC, 64, cycles in BUSY before abort (used only with LSU_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  core request valid
o_req_ready  out  1  LSU can accept (state IDLE)
i_req_wren  in  1  1 store, 0 load
i_req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data, right-aligned
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_rdata  out  32  load result, held until next o_rsp_valid
o_rsp_err  out  1  misaligned/illegal/fault/timeout, qualified by o_rsp_valid
o_ADDR  out  18  memory byte address
o_WDATA  out  32  lane-replicated store data
o_BMASK  out  4  byte enables
o_WREN  out  1  1 write, 0 read
i_RDATA  in  32  memory read word
o_VALID  out  1  memory request valid
i_READY  in  1  memory ready/ack

Behaviour:
- Clock/reset: single clock i_clk; reset i_rst_n is asynchronous, active-low. Reset values: state IDLE, o_VALID 0, o_rsp_valid 0, o_rsp_err 0, o_rsp_rdata 0, o_ADDR/o_WDATA/o_BMASK/o_WREN 0.
- States: IDLE, BUSY, ERR.
  - IDLE: o_req_ready=1. On i_req_valid, latch request. If invalid -> ERR, else -> BUSY.
  - Invalid conditions: funct3 011/110/111; store with funct3[2]=1; H with addr[0]=1; W with addr[1:0]!=0; any set bit in addr[31:ADDR_W].
  - BUSY: o_VALID=1. ADDR/WDATA/BMASK/WREN are registered and stable until the handshake.
  - Handshake completes in the cycle o_VALID&i_READY. Then: o_rsp_valid=1 next cycle, o_rsp_err=0, loads register the extracted i_RDATA, state -> IDLE. o_VALID drops the cycle after the handshake.
  - ERR: one cycle with o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata unchanged; -> IDLE. No memory request is issued.
- Latency, flop memory: accept at cycle N, VALID at N+1, o_rsp_valid at N+2. Next accept allowed at N+2.
- Latency, SRAM memory: add (ack delay) cycles. o_req_ready=0 throughout BUSY/ERR.
- Store mask:
  - B: 0001<<addr[1:0], WDATA={4{wdata[7:0]}}
  - H: 0011<<{addr[1],1'b0}, WDATA={2{wdata[15:0]}}
  - W: 1111
- Loads drive the same mask and o_WREN=0.
- Load extract:
  - B/BU: byte addr[1:0], sign-/zero-extended.
  - H/HU: halfword addr[1], sign-/zero-extended.
  - W: whole word.
- o_ADDR = latched addr[17:0] (ADDR_W<=18; upper bits zero if ADDR_W<18).
- i_READY while o_VALID=0 is ignored. Reset mid-BUSY: VALID drops immediately (async), request lost, no o_rsp_valid.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: counter cleared on entering BUSY, increments each BUSY cycle without i_READY. On reaching TIMEOUT_CYC-1 without handshake: o_VALID drops, go to ERR, o_rsp_err=1. A handshake in the same cycle as the terminal count wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- singlecycle_pkg: lsu_state_e (IDLE, BUSY, ERR); funct3 localparams LSU_B/LSU_H/LSU_W/LSU_BU/LSU_HU.
- Sub-module lsu_align: purely combinational. Performs store mask/replication and load extraction, plus the misalign/illegal check. Reused by the pipelined core.

Test Plan:
- SB addr 0x00003, wdata 0x000000A5, READY=1 -> BMASK 1000, WDATA 0xA5A5A5A5, WREN 1, o_rsp_valid 2 cycles after accept, err 0.
- LB addr 0x00002, RDATA 0x1280_3344 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x00002 -> 0x00001280.
- LW addr 0x00006 -> no o_VALID, o_rsp_valid+err next cycle. Addr 0x0004_0000 (ADDR_W=18) -> err. funct3 011 -> err.
- SW addr 0x00010, READY held low 5 cycles -> VALID/ADDR/WDATA stable 6 cycles, one o_rsp_valid after READY, o_req_ready low throughout.
- Reset asserted mid-BUSY -> o_VALID 0 without clock edge, no response; next request completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=8, READY never -> VALID high 8 cycles, then err response. READY in cycle 8 -> normal completion.
